// File: rtl/expression_tokenizer_pkg.sv
// Shared constants for the expression tokenizer: FSM states, the ASCII set the
// parser pipeline agrees on, and the character classifier.
package expression_tokenizer_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_NUM      = 2'd1,
    S_EMIT_NUM = 2'd2,
    S_EMIT_OP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_DIGIT   = 2'd0,
    C_OP      = 2'd1,
    C_WS      = 2'd2,
    C_INVALID = 2'd3
  } char_class_e;

  // Operator codes must match what the converter and calculator compare against.
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_EQUALS = 8'h3D;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_TAB    = 8'h09;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;

  function automatic char_class_e classify(input logic [7:0] c);
    char_class_e cls;
    if ((c >= CH_ZERO) && (c <= CH_NINE)) begin
      cls = C_DIGIT;
    end else begin
      case (c)
        CH_PLUS, CH_MINUS, CH_STAR, CH_SLASH,
        CH_LPAREN, CH_RPAREN, CH_EQUALS: cls = C_OP;
        CH_SPACE, CH_TAB, CH_LF, CH_CR:  cls = C_WS;
        default:                         cls = C_INVALID;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/expression_tokenizer_decimal_accumulator.sv
// Combinational decimal digit folding: next = acc*10 + digit, saturating to
// all-ones with an overflow flag when the result exceeds DATA_WIDTH bits.
module decimal_accumulator #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_acc,
  input  logic [3:0]            i_digit,
  output logic [DATA_WIDTH-1:0] o_acc,
  output logic                  o_ovf
);

  logic [DATA_WIDTH+3:0] w_wide;
  logic [DATA_WIDTH+3:0] w_acc_ext;

  // acc*10 as (acc<<3)+(acc<<1); four headroom bits cover the worst case.
  always_comb begin
    w_acc_ext = {4'd0, i_acc};
    w_wide    = (w_acc_ext << 3) + (w_acc_ext << 1) + {{DATA_WIDTH{1'b0}}, i_digit};
    o_ovf     = |w_wide[DATA_WIDTH+3:DATA_WIDTH];
    if (o_ovf) begin
      o_acc = {DATA_WIDTH{1'b1}};
    end else begin
      o_acc = w_wide[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/expression_tokenizer.sv
// ASCII-to-token front end: skips whitespace, folds digit runs into operands,
// forwards operators, and presents tokens on a stb/ack handshake.
module expression_tokenizer
  import expression_tokenizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  char_stb,
  input  logic [7:0]            char_data,
  output logic                  char_ack,
  output logic                  output_stb,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  is_output_operator,
  input  logic                  output_ack,
  output logic                  error
);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [7:0]            r_op;
  logic                  r_op_pend;
  logic                  r_char_ack;
  logic                  r_output_stb;
  logic [DATA_WIDTH-1:0] r_output_data;
  logic                  r_is_op;
  logic                  r_error;

  state_e                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic [7:0]            w_op_nxt;
  logic                  w_op_pend_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_is_op_nxt;
  logic                  w_error_nxt;
  logic                  w_accept;
  logic                  w_handshake;
  char_class_e           w_class;
  logic [DATA_WIDTH-1:0] w_acc_sum;
  logic                  w_acc_ovf;
  logic [DATA_WIDTH-1:0] w_op_token;
  logic [DATA_WIDTH-1:0] w_char_token;

  decimal_accumulator #(.DATA_WIDTH(DATA_WIDTH)) u_acc (
    .i_acc   (r_acc),
    .i_digit (char_data[3:0]),
    .o_acc   (w_acc_sum),
    .o_ovf   (w_acc_ovf)
  );

  assign w_accept     = char_stb && r_char_ack;
  assign w_handshake  = r_output_stb && output_ack;
  assign w_class      = classify(char_data);
  assign w_op_token   = {{(DATA_WIDTH-8){1'b0}}, r_op};
  assign w_char_token = {{(DATA_WIDTH-8){1'b0}}, char_data};

  // Next-state and next-output decode; the token payload is loaded on the
  // edge that enters an EMIT state so it is already stable while presented.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_op_nxt      = r_op;
    w_op_pend_nxt = r_op_pend;
    w_data_nxt    = r_output_data;
    w_is_op_nxt   = r_is_op;
    w_error_nxt   = r_error;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_class)
            C_DIGIT: begin
              w_acc_nxt   = {{(DATA_WIDTH-4){1'b0}}, char_data[3:0]};
              w_state_nxt = S_NUM;
            end
            C_OP: begin
              w_op_nxt    = char_data;
              w_data_nxt  = w_char_token;
              w_is_op_nxt = 1'b1;
              w_state_nxt = S_EMIT_OP;
            end
            C_WS:    w_state_nxt = S_IDLE;
            default: w_error_nxt = 1'b1;
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_NUM: begin
        if (w_accept) begin
          case (w_class)
            C_DIGIT: begin
              w_acc_nxt   = w_acc_sum;
              w_error_nxt = r_error | w_acc_ovf;
            end
            C_OP: begin
              w_op_nxt      = char_data;
              w_op_pend_nxt = 1'b1;
              w_data_nxt    = r_acc;
              w_is_op_nxt   = 1'b0;
              w_state_nxt   = S_EMIT_NUM;
            end
            C_WS: begin
              w_op_pend_nxt = 1'b0;
              w_data_nxt    = r_acc;
              w_is_op_nxt   = 1'b0;
              w_state_nxt   = S_EMIT_NUM;
            end
            default: begin
              w_error_nxt   = 1'b1;
              w_op_pend_nxt = 1'b0;
              w_data_nxt    = r_acc;
              w_is_op_nxt   = 1'b0;
              w_state_nxt   = S_EMIT_NUM;
            end
          endcase
        end else begin
          w_state_nxt = S_NUM;
        end
      end
      S_EMIT_NUM: begin
        if (w_handshake && r_op_pend) begin
          w_data_nxt    = w_op_token;
          w_is_op_nxt   = 1'b1;
          w_op_pend_nxt = 1'b0;
          w_state_nxt   = S_EMIT_OP;
        end else if (w_handshake) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_EMIT_NUM;
        end
      end
      S_EMIT_OP: begin
        if (w_handshake) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_EMIT_OP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state       <= S_IDLE;
      r_acc         <= {DATA_WIDTH{1'b0}};
      r_op          <= 8'd0;
      r_op_pend     <= 1'b0;
      r_char_ack    <= 1'b1;
      r_output_stb  <= 1'b0;
      r_output_data <= {DATA_WIDTH{1'b0}};
      r_is_op       <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_op          <= w_op_nxt;
      r_op_pend     <= w_op_pend_nxt;
      r_char_ack    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_NUM);
      r_output_stb  <= (w_state_nxt == S_EMIT_NUM) || (w_state_nxt == S_EMIT_OP);
      r_output_data <= w_data_nxt;
      r_is_op       <= w_is_op_nxt;
      r_error       <= w_error_nxt;
    end
  end

  assign char_ack           = r_char_ack;
  assign output_stb         = r_output_stb;
  assign output_data        = r_output_data;
  assign is_output_operator = r_is_op;
  assign error              = r_error;

endmodule

// File: tb/tb_expression_tokenizer.sv
// Scoreboard bench for expression_tokenizer: a string-level tokenizer model
// queues expected tokens, a negedge monitor pops and compares on handshakes.
module tb_expression_tokenizer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        char_stb = 1'b0;
  logic [7:0]  char_data = 8'd0;
  logic        char_ack;
  logic        output_stb;
  logic [31:0] output_data;
  logic        is_output_operator;
  logic        output_ack = 1'b0;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q[$];
  bit          m_in_num;
  longint      m_val;
  bit          m_err;
  int          ack_mode = 0;
  bit          gaps_on = 0;
  bit          hold_v = 0;
  logic [32:0] held;

  expression_tokenizer #(.DATA_WIDTH(32)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .char_stb           (char_stb),
    .char_data          (char_data),
    .char_ack           (char_ack),
    .output_stb         (output_stb),
    .output_data        (output_data),
    .is_output_operator (is_output_operator),
    .output_ack         (output_ack),
    .error              (error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready: always, random, or held low.
  always @(posedge CLK) begin
    #2;
    case (ack_mode)
      0:       output_ack = 1'b1;
      1:       output_ack = 1'($urandom_range(0, 1));
      default: output_ack = 1'b0;
    endcase
  end

  // Monitor: protocol invariant, stability while stalled, scoreboard pop.
  always @(negedge CLK) begin
    if (RST) begin
      check("char_ack_excl_stb", {63'd0, char_ack}, {63'd0, !output_stb});
      if (output_stb) begin
        if (hold_v) check("hold_stable", {31'd0, is_output_operator, output_data}, {31'd0, held});
        if (output_ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_token", {31'd0, is_output_operator, output_data}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("token", {31'd0, is_output_operator, output_data}, {31'd0, exp_q.pop_front()});
          end
          hold_v = 0;
        end else begin
          hold_v = 1;
          held   = {is_output_operator, output_data};
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic push_num();
    exp_q.push_back({1'b0, m_val[31:0]});
    m_in_num = 0;
  endtask

  // Reference tokenizer working on whole characters and integer values.
  task automatic model_char(input logic [7:0] c, output bit exp_stb);
    exp_stb = 0;
    if (c >= "0" && c <= "9") begin
      if (m_in_num) begin
        m_val = m_val * 10 + longint'(c - "0");
        if (m_val > 64'hFFFF_FFFF) begin
          m_val = 64'hFFFF_FFFF;
          m_err = 1;
        end
      end else begin
        m_in_num = 1;
        m_val    = longint'(c - "0");
      end
    end else if (c inside {"+", "-", "*", "/", "(", ")", "="}) begin
      if (m_in_num) push_num();
      exp_q.push_back({1'b1, 24'd0, c});
      exp_stb = 1;
    end else if (c inside {8'h20, 8'h09, 8'h0D, 8'h0A}) begin
      if (m_in_num) begin
        push_num();
        exp_stb = 1;
      end
    end else begin
      m_err = 1;
      if (m_in_num) begin
        push_num();
        exp_stb = 1;
      end
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int w = 0;
    bit exp_stb;
    char_stb  = 1'b1;
    char_data = c;
    while (!char_ack && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!char_ack) begin
      check("char_ack_timeout", 64'd0, 64'd1);
      char_stb = 1'b0;
      return;
    end
    model_char(c, exp_stb);
    @(negedge CLK);
    char_stb = 1'b0;
    check("stb_latency", {63'd0, output_stb}, {63'd0, exp_stb});
    check("error_flag", {63'd0, error}, {63'd0, m_err});
    if (gaps_on) repeat ($urandom_range(0, 2)) @(negedge CLK);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      @(negedge CLK);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge CLK);
    check("error_end", {63'd0, error}, {63'd0, m_err});
  endtask

  task automatic do_reset();
    char_stb = 1'b0;
    RST      = 1'b0;
    exp_q.delete();
    m_in_num = 0;
    m_val    = 0;
    m_err    = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  logic [7:0] ops[7]  = '{8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h28, 8'h29, 8'h3D};
  logic [7:0] wss[4]  = '{8'h20, 8'h09, 8'h0D, 8'h0A};
  logic [7:0] bads[5] = '{8'h61, 8'h23, 8'h2E, 8'h00, 8'h3A};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_char_ack", {63'd0, char_ack}, 64'd1);
    check("rst_output_stb", {63'd0, output_stb}, 64'd0);
    check("rst_output_data", {32'd0, output_data}, 64'd0);
    check("rst_is_op", {63'd0, is_output_operator}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    do_reset();

    ack_mode = 0;
    send_str("12+3=");
    drain();

    do_reset();
    send_str(" ( 7 ) ");
    send_str("=");
    drain();

    do_reset();
    ack_mode = 2;
    send_str("45*");
    for (int i = 0; i < 5; i++) begin
      check("stall_stb", {63'd0, output_stb}, 64'd1);
      check("stall_data", {31'd0, is_output_operator, output_data}, {31'd0, 1'b0, 32'd45});
      check("stall_char_ack", {63'd0, char_ack}, 64'd0);
      @(negedge CLK);
    end
    ack_mode = 0;
    drain();

    do_reset();
    send_str("4294967295");
    send_str("0=");
    drain();

    do_reset();
    send_str("9a+");
    drain();

    do_reset();
    ack_mode = 2;
    send_str("5 ");
    #3;
    RST = 1'b0;
    #1;
    check("async_rst_stb", {63'd0, output_stb}, 64'd0);
    check("async_rst_char_ack", {63'd0, char_ack}, 64'd1);
    exp_q.delete();
    m_in_num = 0;
    m_err    = 0;
    @(negedge CLK);
    RST      = 1'b1;
    ack_mode = 0;
    @(negedge CLK);
    send_str("8=");
    drain();

    for (int s = 0; s < 12; s++) begin
      do_reset();
      ack_mode = (s % 3 == 0) ? 0 : 1;
      gaps_on  = (s % 2 == 1);
      for (int k = 0; k < 30; k++) begin
        int r = $urandom_range(0, 99);
        if (r < 50)      send_char(8'h30 + 8'($urandom_range(0, 9)));
        else if (r < 75) send_char(ops[$urandom_range(0, 6)]);
        else if (r < 92) send_char(wss[$urandom_range(0, 3)]);
        else if (r < 96) send_char(bads[$urandom_range(0, 4)]);
        else             send_str("98765432109");
      end
      send_char(8'h3D);
      drain();
    end
    gaps_on  = 0;
    ack_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expression_tokenizer.md
# expression_tokenizer

Character-level front end for the expression parser pipeline. Consumes an ASCII byte stream, skips whitespace, folds decimal digit runs into 32-bit unsigned operand tokens, and emits operator tokens. Its output drives the converter's token input (`input_stb`/`input_data`/`is_input_operator`/`input_ack`) directly, with the same stb/ack protocol.

## Interface
- `DATA_WIDTH`, 32: token payload width. Must match the converter's data width.
- `CLK` input 1: single clock; all state changes on its rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `char_stb` input 1: upstream byte valid.
- `char_data` input 8: ASCII byte.
- `char_ack` output 1: byte accepted on an edge where `char_stb && char_ack`.
- `output_stb` output 1: token valid.
- `output_data` output DATA_WIDTH: operand value, or the operator's ASCII code zero-extended.
- `is_output_operator` output 1: 1 = operator token, 0 = operand token.
- `output_ack` input 1: downstream accepts the token on an edge where `output_stb && output_ack`.
- `error` output 1: sticky flag for an invalid character or numeric overflow. Cleared only by reset.

## Operation
- Character classes:
  - digit: `'0'`–`'9'`.
  - operator: `'+'`, `'-'`, `'*'`, `'/'`, `'('`, `')'`, `'='`.
  - whitespace: space, TAB, CR, LF.
  - anything else is invalid.
- States: `S_IDLE`, `S_NUM`, `S_EMIT_NUM`, `S_EMIT_OP`.
- `S_IDLE`, on an accepted byte:
  - digit: `acc <= digit`, go to `S_NUM`.
  - operator: `op_reg <= char`, go to `S_EMIT_OP`.
  - whitespace: stay.
  - invalid: set `error`, stay.
- `S_NUM`, on an accepted byte:
  - digit: `acc <= acc*10 + digit`, stay.
  - operator: `op_reg <= char`, `op_pend <= 1`, go to `S_EMIT_NUM`.
  - whitespace: `op_pend <= 0`, go to `S_EMIT_NUM`.
  - invalid: set `error`, `op_pend <= 0`, go to `S_EMIT_NUM`. The byte is dropped and the number is terminated.
- `S_EMIT_NUM`:
  - Present `acc` as an operand token.
  - On handshake: go to `S_EMIT_OP` if `op_pend`, else `S_IDLE`.
- `S_EMIT_OP`:
  - Present `{0, op_reg}` as an operator token.
  - On handshake: go to `S_IDLE`.
- `'='` is forwarded as an ordinary operator token and marks end of expression downstream. No other end-of-stream processing.
- Arithmetic: `acc*10 + digit` is computed at DATA_WIDTH+4 bits. If any bit above DATA_WIDTH-1 is set, `acc` saturates to all-ones and `error` is set. Further digits keep it saturated.
- Leading zeros are legal: `"007"` yields 7.

## Timing
- Reset values:
  - state `S_IDLE`, `char_ack` 1, `output_stb` 0, `output_data` 0, `is_output_operator` 0, `error` 0.
  - `acc` 0, `op_reg` 0, `op_pend` 0.
- `char_ack` is registered. It is 1 exactly in `S_IDLE`/`S_NUM` and 0 in both EMIT states, so the block never accepts a byte while holding a token.
- Output signals are registered. `output_stb` is 1 exactly in the EMIT states.
  - `output_data` and `is_output_operator` hold stable while `output_stb` is 1 and `output_ack` is 0.
- Latency:
  - operator byte accepted at edge N (from `S_IDLE`): `output_stb` is high after edge N.
  - operand: the token appears after the edge that accepts the terminating byte.
  - the following operator token appears after the edge that acks the operand token.
- Throughput: with `output_ack` tied high, each token occupies one cycle. `char_ack` returns high after the handshake edge.
- A digit run is only flushed by a terminating byte. An expression must end with `'='` or whitespace to emit its last operand.
- `output_ack` without `output_stb` is ignored. `char_stb` while `char_ack` is 0 is held by upstream, not lost.
- Reset mid-token (asserted asynchronously):
  - pending operand and operator are discarded; `output_stb` drops immediately.
  - after deassertion the block is in `S_IDLE`.

## Structure
- `tokenizer_defs.vh` holds the shared constants:
  - state encodings.
  - ASCII constants for the operator set, digits, and whitespace.
  - The operator codes are the ones the converter and calculator compare against, so they belong in the shared header, not local literals.
- One natural sub-module: `decimal_accumulator`. It is combinational: `acc` plus digit gives the next `acc` and an overflow flag, implementing the saturation rule.
- Top-level wiring: a new `expression_parser_system` wrapper instantiates `expression_tokenizer` in front of the existing converter/calculator top.

## Test plan
- `"12+3="` with `output_ack` high:
  - tokens are (0,12), (1,0x2B), (0,3), (1,0x3D).
  - `error` stays 0.
- `" ( 7 ) "` then `'='`:
  - tokens are (1,0x28), (0,7), (1,0x29), (1,0x3D).
  - whitespace produces no tokens.
- `"45*"` with `output_ack` held low for 5 cycles after `output_stb` rises:
  - (0,45) stays stable and `char_ack` stays 0 throughout.
  - after ack, (1,0x2A) appears.
- `"4294967295"` then `"0="`:
  - `error` rises on the 11th digit.
  - operand token is 0xFFFFFFFF, followed by (1,0x3D).
- `"9a+"`:
  - `'a'` sets `error` and flushes (0,9).
  - `'+'` then yields (1,0x2B).
- `RST` pulsed low while (0,5) is pending:
  - `output_stb` goes to 0 immediately.
  - after release, `"8="` yields (0,8), (1,0x3D) with no stale token.
